// File: rtl/mmio_panel.sv
// Memory-mapped button/7-segment panel for the four-colour CPU data bus.
// Window BASE..BASE+4: debounced buttons at BASE, raw segment bytes for digits 0..3 above it.
module mmio_panel #(
  parameter logic [7:0]  BASE        = 8'hFB,
  parameter logic [15:0] DEB_CYCLES  = 16'd50000,
  parameter logic [15:0] REFRESH_DIV = 16'd10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  output logic       hit,
  output logic [7:0] rdata,
  input  logic [2:0] pb_in,
  output logic [7:0] seg_n,
  output logic [3:0] an_n
);

  if ({1'b0, BASE} + 9'd4 > 9'h0FF) begin : g_base_range
    $error("mmio_panel: BASE+4 must not exceed 8'hFF");
  end
  if (DEB_CYCLES < 16'd2) begin : g_deb_range
    $error("mmio_panel: DEB_CYCLES must be at least 2");
  end
  if (REFRESH_DIV < 16'd1) begin : g_refresh_range
    $error("mmio_panel: REFRESH_DIV must be at least 1");
  end

  typedef enum logic {SHOW, BLANK} disp_state_t;

  logic [7:0]  d_r [4];
  logic [2:0]  sync1_r;
  logic [2:0]  sync2_r;
  logic [2:0]  pb_db_r;
  logic [15:0] deb_cnt_r [3];
  disp_state_t state_r;
  logic [1:0]  idx_r;
  logic [15:0] ref_cnt_r;
  logic [7:0]  seg_r;
  logic [3:0]  an_r;

  logic [7:0]  off_s;
  logic        hit_s;
  logic [7:0]  rdata_s;

  assign off_s = addr - BASE;
  assign hit_s = (addr >= BASE) && (off_s <= 8'd4);

  // Read mux: button state at offset 0, digit readback at offsets 1..4.
  always_comb begin
    rdata_s = 8'h00;
    if (hit_s) begin
      case (off_s[2:0])
        3'd0:    rdata_s = {5'b00000, pb_db_r};
        3'd1:    rdata_s = d_r[0];
        3'd2:    rdata_s = d_r[1];
        3'd3:    rdata_s = d_r[2];
        3'd4:    rdata_s = d_r[3];
        default: rdata_s = 8'h00;
      endcase
    end else begin
      rdata_s = 8'h00;
    end
  end

  assign hit   = hit_s;
  assign rdata = rdata_s;

  // Digit register stores; the button address is read-only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) d_r[i] <= 8'hFF;
    end else if (we && hit_s) begin
      case (off_s[2:0])
        3'd1:    d_r[0] <= wdata;
        3'd2:    d_r[1] <= wdata;
        3'd3:    d_r[2] <= wdata;
        3'd4:    d_r[3] <= wdata;
        default: ;
      endcase
    end
  end

  // Per-bit synchronizer and debounce: the count only runs while the synced sample disagrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      pb_db_r <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt_r[i] <= 16'd0;
    end else begin
      sync1_r <= pb_in;
      sync2_r <= sync1_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == pb_db_r[i]) begin
          deb_cnt_r[i] <= 16'd0;
        end else if (deb_cnt_r[i] == DEB_CYCLES - 16'd1) begin
          pb_db_r[i]   <= ~pb_db_r[i];
          deb_cnt_r[i] <= 16'd0;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + 16'd1;
        end
      end
    end
  end

  // Display multiplexer: REFRESH_DIV clocks per digit, then one blank clock against ghosting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= SHOW;
      idx_r     <= 2'd0;
      ref_cnt_r <= 16'd0;
      seg_r     <= 8'hFF;
      an_r      <= 4'hF;
    end else begin
      case (state_r)
        SHOW: begin
          seg_r <= d_r[idx_r];
          an_r  <= ~(4'b0001 << idx_r);
          if (ref_cnt_r == REFRESH_DIV - 16'd1) begin
            state_r   <= BLANK;
            ref_cnt_r <= 16'd0;
          end else begin
            ref_cnt_r <= ref_cnt_r + 16'd1;
          end
        end
        BLANK: begin
          seg_r     <= 8'hFF;
          an_r      <= 4'hF;
          idx_r     <= idx_r + 2'd1;
          ref_cnt_r <= 16'd0;
          state_r   <= SHOW;
        end
        default: begin
          seg_r     <= 8'hFF;
          an_r      <= 4'hF;
          idx_r     <= 2'd0;
          ref_cnt_r <= 16'd0;
          state_r   <= SHOW;
        end
      endcase
    end
  end

  assign seg_n = seg_r;
  assign an_n  = an_r;

endmodule

// File: tb/tb_mmio_panel.sv
// Directed self-checking bench for mmio_panel with DEB_CYCLES=4, REFRESH_DIV=3.
module tb_mmio_panel;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       hit;
  logic [7:0] rdata;
  logic [2:0] pb_in;
  logic [7:0] seg_n;
  logic [3:0] an_n;

  int tests_run;
  int tests_failed;

  mmio_panel #(
    .BASE(8'hFB),
    .DEB_CYCLES(16'd4),
    .REFRESH_DIV(16'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wdata(wdata),
    .we(we),
    .hit(hit),
    .rdata(rdata),
    .pb_in(pb_in),
    .seg_n(seg_n),
    .an_n(an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] exp_an  [17] = '{4'b1110, 4'b1110, 4'b1110, 4'b1111,
                               4'b1101, 4'b1101, 4'b1101, 4'b1111,
                               4'b1011, 4'b1011, 4'b1011, 4'b1111,
                               4'b0111, 4'b0111, 4'b0111, 4'b1111,
                               4'b1110};
  logic [7:0] exp_seg [17] = '{8'hA4, 8'hA4, 8'hA4, 8'hFF,
                               8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h99, 8'h99, 8'h99, 8'hFF,
                               8'hC0, 8'hC0, 8'hC0, 8'hFF,
                               8'hA4};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] v);
    addr  = a;
    wdata = v;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [7:0] a,
                            input logic exp_hit, input logic [7:0] exp_rd);
    addr = a;
    #1;
    tests_run++;
    if (hit !== exp_hit || rdata !== exp_rd) begin
      $display("FAIL %s addr=%02h: hit=%b rdata=%02h, expected hit=%b rdata=%02h",
               name, a, hit, rdata, exp_hit, exp_rd);
      tests_failed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (seg_n !== 8'hFF || an_n !== 4'hF) begin
      $display("FAIL reset_outputs: seg_n=%02h an_n=%b, expected FF 1111", seg_n, an_n);
      tests_failed++;
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (seg_n !== 8'hFF || an_n !== 4'b1110) begin
      $display("FAIL first_show: seg_n=%02h an_n=%b, expected FF 1110", seg_n, an_n);
      tests_failed++;
    end
    check_read("reset_btn", 8'hFB, 1'b1, 8'h00);
    check_read("reset_d0",  8'hFC, 1'b1, 8'hFF);
    check_read("reset_d1",  8'hFD, 1'b1, 8'hFF);
    check_read("reset_d2",  8'hFE, 1'b1, 8'hFF);
    check_read("reset_d3",  8'hFF, 1'b1, 8'hFF);
    check_read("below_window", 8'hFA, 1'b0, 8'h00);
  endtask

  task automatic test_store_readback();
    store(8'hFC, 8'hA4);
    store(8'hFD, 8'hFF);
    store(8'hFE, 8'h99);
    store(8'hFF, 8'hC0);
    check_read("rb_d0", 8'hFC, 1'b1, 8'hA4);
    check_read("rb_d1", 8'hFD, 1'b1, 8'hFF);
    check_read("rb_d2", 8'hFE, 1'b1, 8'h99);
    check_read("rb_d3", 8'hFF, 1'b1, 8'hC0);
  endtask

  task automatic test_display();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = an_n;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (prev == 4'b1111 && an_n == 4'b1110) found = 1'b1;
      prev = an_n;
    end
    tests_run++;
    if (!found) begin
      $display("FAIL display_sync: digit0 slot not seen within 40 clocks, last an_n=%b", an_n);
      tests_failed++;
    end else begin
      for (int k = 0; k < 17; k++) begin
        if (k > 0) tick();
        tests_run++;
        if (an_n !== exp_an[k] || seg_n !== exp_seg[k]) begin
          $display("FAIL display_slot%0d: an_n=%b seg_n=%02h, expected %b %02h",
                   k, an_n, seg_n, exp_an[k], exp_seg[k]);
          tests_failed++;
        end
      end
    end
  endtask

  task automatic test_debounce();
    addr  = 8'hFB;
    pb_in = 3'b010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests_run++;
      if (rdata !== ((k == 6) ? 8'h02 : 8'h00)) begin
        $display("FAIL press_clk%0d: rdata=%02h, expected %02h", k, rdata,
                 (k == 6) ? 8'h02 : 8'h00);
        tests_failed++;
      end
    end
    pb_in = 3'b000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests_run++;
      if (rdata !== ((k == 6) ? 8'h00 : 8'h02)) begin
        $display("FAIL release_clk%0d: rdata=%02h, expected %02h", k, rdata,
                 (k == 6) ? 8'h00 : 8'h02);
        tests_failed++;
      end
    end
  endtask

  task automatic test_glitch();
    bit bad;
    addr  = 8'hFB;
    bad   = 1'b0;
    pb_in = 3'b100;
    repeat (3) begin
      tick();
      if (rdata !== 8'h00) bad = 1'b1;
    end
    pb_in = 3'b000;
    repeat (10) begin
      tick();
      if (rdata !== 8'h00) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      $display("FAIL short_glitch: rdata left 00 (now %02h), expected 00 throughout", rdata);
      tests_failed++;
    end
    pb_in = 3'b100;
    repeat (8) tick();
    tests_run++;
    if (rdata !== 8'h04) begin
      $display("FAIL long_pulse: rdata=%02h, expected 04", rdata);
      tests_failed++;
    end
    pb_in = 3'b000;
    repeat (8) tick();
    tests_run++;
    if (rdata !== 8'h00) begin
      $display("FAIL long_pulse_release: rdata=%02h, expected 00", rdata);
      tests_failed++;
    end
  endtask

  task automatic test_ignored_writes();
    store(8'hFB, 8'h55);
    store(8'h40, 8'h12);
    check_read("btn_after_store", 8'hFB, 1'b1, 8'h00);
    check_read("keep_d0", 8'hFC, 1'b1, 8'hA4);
    check_read("keep_d1", 8'hFD, 1'b1, 8'hFF);
    check_read("keep_d2", 8'hFE, 1'b1, 8'h99);
    check_read("keep_d3", 8'hFF, 1'b1, 8'hC0);
    check_read("outside", 8'h40, 1'b0, 8'h00);
  endtask

  task automatic test_reset_in_blank();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = an_n;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (prev == 4'b1011 && an_n == 4'b1111) found = 1'b1;
      prev = an_n;
    end
    tests_run++;
    if (!found) begin
      $display("FAIL blank_sync: blank after digit2 not seen, last an_n=%b", an_n);
      tests_failed++;
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (seg_n !== 8'hFF || an_n !== 4'hF) begin
      $display("FAIL rst_blank_out: seg_n=%02h an_n=%b, expected FF 1111", seg_n, an_n);
      tests_failed++;
    end
    check_read("rst_blank_d2", 8'hFE, 1'b1, 8'hFF);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (an_n !== ((k == 3) ? 4'b1111 : 4'b1110) || seg_n !== 8'hFF) begin
        $display("FAIL restart_clk%0d: an_n=%b seg_n=%02h, expected %b FF", k, an_n, seg_n,
                 (k == 3) ? 4'b1111 : 4'b1110);
        tests_failed++;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    addr  = 8'h00;
    wdata = 8'h00;
    we    = 1'b0;
    pb_in = 3'b000;
    test_reset();
    test_store_readback();
    test_display();
    test_debounce();
    test_glitch();
    test_ignored_writes();
    test_reset_in_blank();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
